// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg : shared constants, state encoding and address helper for the
//            synchronous instruction memory.
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // Opcodes already in use by the processor core
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } imem_state_t;

   // Byte address to word index; callers truncate to their index width
   function automatic logic [31:0] idx_of(input logic [31:0] addr);
      return {2'b00, addr[31:2]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sp_ram_rf.sv
// ============================================================================
// sp_ram_rf : one-write / one-read synchronous RAM, read-first, no reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module sp_ram_rf #(
   parameter int DEPTH      = 128,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [IDX_W-1:0]      i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Both updates are non-blocking, so a same-cycle read sees the old word
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/instruction_memory_sync.sv
// ============================================================================
// instruction_memory_sync : word-aligned instruction store with programming
//                           port, NOP clear sweep and one-cycle fetch.
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_memory_sync
   import imem_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DEPTH_WORDS = 128,
   parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] PC,
   output logic                  ready,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  misaligned_fault,
   output logic                  range_fault,
   input  logic                  prog_we,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   output logic                  prog_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [DATA_WIDTH-1:0] c_NOP = DATA_WIDTH'(NOP_WORD);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   imem_state_t            r_state;
   imem_state_t            w_next;
   logic [IDX_W-1:0]       r_clr_cnt;
   logic                   r_ready;
   logic                   r_valid;
   logic                   r_mis;
   logic                   r_rng;
   logic                   r_out_nop;
   logic                   r_perr;

   logic [IDX_W-1:0]       w_fetch_idx;
   logic [IDX_W-1:0]       w_prog_idx;
   logic                   w_fetch_mis;
   logic                   w_fetch_rng;
   logic                   w_fetch_acc;
   logic                   w_prog_ok;
   logic                   w_clr_we;
   logic                   w_ram_we;
   logic [IDX_W-1:0]       w_ram_waddr;
   logic [DATA_WIDTH-1:0]  w_ram_wdata;
   logic                   w_ram_re;
   logic [DATA_WIDTH-1:0]  w_ram_rdata;

   assign w_fetch_idx = IDX_W'(idx_of(32'(PC)));
   assign w_prog_idx  = IDX_W'(idx_of(32'(prog_addr)));
   assign w_fetch_mis = |PC[1:0];
   assign w_fetch_rng = |PC[ADDR_WIDTH-1:IDX_W+2];
   assign w_fetch_acc = fetch_req & r_ready;
   assign w_prog_ok   = prog_we & r_ready & ~reset & ~(|prog_addr[1:0])
                        & ~(|prog_addr[ADDR_WIDTH-1:IDX_W+2]);

   // Clear sweep and programming port never overlap since prog needs ready
   assign w_clr_we    = (r_state == ST_CLEAR) & ~reset;
   assign w_ram_we    = w_clr_we | w_prog_ok;
   assign w_ram_waddr = w_clr_we ? r_clr_cnt : w_prog_idx;
   assign w_ram_wdata = w_clr_we ? c_NOP : prog_data;
   assign w_ram_re    = w_fetch_acc & ~w_fetch_mis & ~w_fetch_rng;

   sp_ram_rf #(
      .DEPTH      (DEPTH_WORDS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_re    (w_ram_re),
      .i_raddr (w_fetch_idx),
      .o_rdata (w_ram_rdata)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_clr_cnt == c_LAST_IDX) w_next = ST_READY;
         ST_READY: w_next = ST_READY;
         default:  w_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
         r_valid   <= 1'b0;
         r_mis     <= 1'b0;
         r_rng     <= 1'b0;
         r_out_nop <= 1'b1;
         r_perr    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == ST_READY);
         if (r_state == ST_CLEAR)
            r_clr_cnt <= r_clr_cnt + 1'b1;
         r_valid <= w_fetch_acc;
         r_mis   <= w_fetch_acc & w_fetch_mis;
         r_rng   <= w_fetch_acc & w_fetch_rng;
         // Output word follows the RAM only for clean fetches, else NOP; holds otherwise
         if (w_fetch_acc)
            r_out_nop <= w_fetch_mis | w_fetch_rng;
         r_perr <= prog_we & ~w_prog_ok;
      end
   end

   assign ready            = r_ready;
   assign instr_valid      = r_valid;
   assign misaligned_fault = r_mis;
   assign range_fault      = r_rng;
   assign prog_err         = r_perr;
   assign instruction      = r_out_nop ? c_NOP : w_ram_rdata;

endmodule

`default_nettype wire
